interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Interrupt factor/mask block for the E0C6S46 core. It latches timer, stopwatch, programmable-timer, serial and K-port events into nibble-wide factor flags, gates them with software mask registers, and drives the 15-bit `interrupt_req` vector. That vector is consumed directly by the microcode sequencer, which selects the highest set bit as the vector address. The CPU clears factor flags by reading them through the 4-bit I/O bus; servicing an interrupt does not clear them.

## Interface
- `K0_WIDTH`, default 4: number of K0 input pins; each has its own enable and compare bit.
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high; clock `clk`.
- `clk_en` input 1: CPU tick. All state updates happen only on `clk` edges where `clk_en`=1.
- `cs` input 1: register select. The I/O decoder asserts it for 0xF0–0xFF.
- `reg_addr` input 4: register index, equal to address[3:0].
- `bus_wr` input 1: write strobe, qualified by `cs`.
- `bus_rd` input 1: read strobe, qualified by `cs`.
- `bus_wdata` input 4: write nibble.
- `bus_rdata` output 4: combinational read nibble. It is 0 when not (`cs` && `bus_rd`).
- `ev_clk` input 4: clock-timer pulses, one `clk_en` wide. Bit order is {1Hz, 2Hz, 8Hz, 32Hz}.
- `ev_sw` input 2: stopwatch pulses, {1Hz, 10Hz}.
- `ev_pt` input 1: programmable-timer underflow pulse.
- `ev_sio` input 1: serial transfer-complete pulse.
- `k0_in` input `K0_WIDTH`: asynchronous K00–K03 pin levels.
- `k1_in` input 1: asynchronous K10 pin level.
- `interrupt_req` output 15: request vector to the sequencer. Bit index equals interrupt address.

## Operation
Register map (`reg_addr`):
- Factor registers, read-clear, writes ignored:
  - 0x0 IT[3:0]
  - 0x1 ISW[1:0], bits 3:2 read 0
  - 0x2 IPT[0]
  - 0x3 ISIO[0]
  - 0x4 IK0[0]
  - 0x5 IK1[0]
- Mask and control registers, read/write; unused bits read 0:
  - 0x8 EIT[3:0]
  - 0x9 EISW[1:0]
  - 0xA EIPT[0]
  - 0xB EISIO[0]
  - 0xC EIK0[3:0]
  - 0xD EIK1[0]
  - 0xE KCP0[3:0]: per-pin compare level
  - 0xF KCP1[0]
- Unmapped indices 0x6, 0x7 read 0; writes to them are ignored.

Factor flag rules:
- Each event bit sets its factor bit on a `clk_en` cycle, regardless of mask.
- A read of a factor register (`cs`&&`bus_rd`&&`clk_en`) returns the pre-clear value and clears every bit of that register.
- Read-clear and a new event on the same bit in the same cycle: the set wins, so the flag is 1 afterwards and the read returns the old value.

K-port path:
- Each pin passes through a 2-FF synchronizer clocked on `clk_en`, then a previous-level register.
- K0 pin i raises a K0 edge when the synchronized level changes to `KCP0[i]` while `EIK0[i]`=1. A disabled pin never sets IK0.
- Any K0 edge sets IK0.
- K1 follows the same rule, using KCP1 and EIK1, and sets IK1.

`interrupt_req` is registered, updated on every `clk_en`. Each bit is the OR of its group's factor bits ANDed with the matching mask bits:
- bit 6: PT (IPT&EIPT)
- bit 5: SIO
- bit 4: K0 (IK0; the mask is already applied at the edge)
- bit 3: K1
- bit 2: SW (|(ISW&EISW))
- bit 1: CLK (|(IT&EIT))
- bits 14:7 and 0 are 0.

The CPU interrupt flag and the sequencer gate `interrupt_req` downstream; this block holds requests until software clears the factor.

## Timing
- Reset state:
  - all factor, mask, KCP0 and KCP1 registers 0
  - synchronizer and previous-level registers all 1 (idle-high pull-ups)
  - `interrupt_req` 0
  - `bus_rdata` 0
- Latency, in `clk_en` ticks:
  - event pulse to factor bit: 1
  - factor bit to `interrupt_req`: 1
  - K pin change to `interrupt_req`: 4 (2 sync, 1 edge/flag, 1 request)
- Mask write: takes effect on the request at the next `clk_en` after the write.
- Factor read-clear: drops the request at the `clk_en` after the clear, unless a same-cycle event re-set the flag.
- `clk_en`=0: all state holds, including bus side effects. `bus_rdata` still reflects the current registers.
- Reset mid-access: reset wins; the write is discarded and no clear occurs.

## Test plan
- Reset, then `ev_pt` pulse with EIPT=0 → IPT=1 on readback of 0x2, `interrupt_req`=0. Write 0xA=1 → `interrupt_req`=15'h0040 on the next tick.
- EIT=4'b0100, `ev_clk`=4'b0101 → IT=0x5, `interrupt_req[1]`=1. Read 0x0 → returns 0x5, then reads 0x0, and `interrupt_req[1]`=0 on the following tick.
- Read 0x1 in the same tick as `ev_sw[0]`, with ISW=2'b10 beforehand → read returns 0x2, ISW=2'b01 afterwards.
- EIK0=4'b0001, KCP0=0, drive `k0_in[0]` 1→0 → `interrupt_req[4]`=1 exactly 4 ticks later. The same edge on pin 1 (disabled) → IK0 stays 0.
- Simultaneous PT, SIO and CLK requests with all masks set → `interrupt_req`=15'h0062. Clear IPT → 15'h0022.
- Assert `reset` while factors and masks are nonzero and `bus_wr` is active → all outputs 0, and registers read 0 afterwards.

Source files
------------

// File: rtl/interrupt_controller_if.sv
// Register-bus bundle between the I/O decoder (master) and the interrupt
// factor/mask block (slave). The decoder owns select, strobes and write data;
// the block returns a combinational read nibble.
interface interrupt_controller_if;
   logic       cs;
   logic [3:0] reg_addr;
   logic       bus_wr;
   logic       bus_rd;
   logic [3:0] bus_wdata;
   logic [3:0] bus_rdata;

   modport master (
      output cs,
      output reg_addr,
      output bus_wr,
      output bus_rd,
      output bus_wdata,
      input  bus_rdata
   );

   modport slave (
      input  cs,
      input  reg_addr,
      input  bus_wr,
      input  bus_rd,
      input  bus_wdata,
      output bus_rdata
   );
endinterface

// File: rtl/interrupt_controller.sv
// Interrupt factor/mask block for the E0C6S46 core. Latches timer, stopwatch,
// programmable-timer, serial and K-port events into factor flags, gates them
// with software masks and presents a registered request vector whose bit index
// is the interrupt address. Factors are cleared only by reading them.
module interrupt_controller #(
   parameter int K0_WIDTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clk_en,
   interrupt_controller_if.slave bus,
   input  logic [3:0]          ev_clk,
   input  logic [1:0]          ev_sw,
   input  logic                ev_pt,
   input  logic                ev_sio,
   input  logic [K0_WIDTH-1:0] k0_in,
   input  logic                k1_in,
   output logic [14:0]         interrupt_req
);

   // Factor flags
   logic [3:0]          it_q,   it_d;
   logic [1:0]          isw_q,  isw_d;
   logic                ipt_q,  ipt_d;
   logic                isio_q, isio_d;
   logic                ik0_q,  ik0_d;
   logic                ik1_q,  ik1_d;

   // Masks and K-port compare levels
   logic [3:0]          eit_q,   eit_d;
   logic [1:0]          eisw_q,  eisw_d;
   logic                eipt_q,  eipt_d;
   logic                eisio_q, eisio_d;
   logic [K0_WIDTH-1:0] eik0_q,  eik0_d;
   logic                eik1_q,  eik1_d;
   logic [K0_WIDTH-1:0] kcp0_q,  kcp0_d;
   logic                kcp1_q,  kcp1_d;

   // K-port synchronizers and previous-level history
   logic [K0_WIDTH-1:0] k0Sync1_q, k0Sync1_d;
   logic [K0_WIDTH-1:0] k0Sync2_q, k0Sync2_d;
   logic [K0_WIDTH-1:0] k0Prev_q,  k0Prev_d;
   logic                k1Sync1_q, k1Sync1_d;
   logic                k1Sync2_q, k1Sync2_d;
   logic                k1Prev_q,  k1Prev_d;

   logic [14:0]         req_q, req_d;

   logic                rdEn;
   logic                wrEn;
   logic [K0_WIDTH-1:0] k0Edge;
   logic                k1Edge;
   logic [3:0]          eik0Nib;
   logic [3:0]          kcp0Nib;
   logic [3:0]          rdataNib;

   // A K edge is a change of the synchronized level onto the programmed
   // compare level on an enabled pin; disabled pins can never raise a factor.
   always_comb begin
      rdEn    = bus.cs && bus.bus_rd && clk_en;
      wrEn    = bus.cs && bus.bus_wr && clk_en;
      k0Edge  = (k0Sync2_q ^ k0Prev_q) & ~(k0Sync2_q ^ kcp0_q) & eik0_q;
      k1Edge  = (k1Sync2_q ^ k1Prev_q) & ~(k1Sync2_q ^ kcp1_q) & eik1_q;
      eik0Nib = '0;
      kcp0Nib = '0;
      eik0Nib[K0_WIDTH-1:0] = eik0_q;
      kcp0Nib[K0_WIDTH-1:0] = kcp0_q;
   end

   // Combinational read mux; idle bus returns 0 and unused bits read 0.
   always_comb begin
      rdataNib = 4'h0;
      if (bus.cs && bus.bus_rd) begin
         case (bus.reg_addr)
            4'h0:    rdataNib = it_q;
            4'h1:    rdataNib = {2'b00, isw_q};
            4'h2:    rdataNib = {3'b000, ipt_q};
            4'h3:    rdataNib = {3'b000, isio_q};
            4'h4:    rdataNib = {3'b000, ik0_q};
            4'h5:    rdataNib = {3'b000, ik1_q};
            4'h8:    rdataNib = eit_q;
            4'h9:    rdataNib = {2'b00, eisw_q};
            4'hA:    rdataNib = {3'b000, eipt_q};
            4'hB:    rdataNib = {3'b000, eisio_q};
            4'hC:    rdataNib = eik0Nib;
            4'hD:    rdataNib = {3'b000, eik1_q};
            4'hE:    rdataNib = kcp0Nib;
            4'hF:    rdataNib = {3'b000, kcp1_q};
            default: rdataNib = 4'h0;
         endcase
      end
   end

   assign bus.bus_rdata = rdataNib;
   assign interrupt_req = req_q;

   // Next-state: on a CPU tick the request samples the current flags, a read
   // clears its factor register, then new events OR in so a same-tick event
   // survives the clear, and mask/compare writes land.
   always_comb begin
      it_d      = it_q;
      isw_d     = isw_q;
      ipt_d     = ipt_q;
      isio_d    = isio_q;
      ik0_d     = ik0_q;
      ik1_d     = ik1_q;
      eit_d     = eit_q;
      eisw_d    = eisw_q;
      eipt_d    = eipt_q;
      eisio_d   = eisio_q;
      eik0_d    = eik0_q;
      eik1_d    = eik1_q;
      kcp0_d    = kcp0_q;
      kcp1_d    = kcp1_q;
      k0Sync1_d = k0Sync1_q;
      k0Sync2_d = k0Sync2_q;
      k0Prev_d  = k0Prev_q;
      k1Sync1_d = k1Sync1_q;
      k1Sync2_d = k1Sync2_q;
      k1Prev_d  = k1Prev_q;
      req_d     = req_q;

      if (clk_en) begin
         k0Sync1_d = k0_in;
         k0Sync2_d = k0Sync1_q;
         k0Prev_d  = k0Sync2_q;
         k1Sync1_d = k1_in;
         k1Sync2_d = k1Sync1_q;
         k1Prev_d  = k1Sync2_q;

         req_d = {8'h00,
                  ipt_q & eipt_q,
                  isio_q & eisio_q,
                  ik0_q,
                  ik1_q,
                  |(isw_q & eisw_q),
                  |(it_q & eit_q),
                  1'b0};

         if (rdEn) begin
            case (bus.reg_addr)
               4'h0:    it_d   = 4'h0;
               4'h1:    isw_d  = 2'b00;
               4'h2:    ipt_d  = 1'b0;
               4'h3:    isio_d = 1'b0;
               4'h4:    ik0_d  = 1'b0;
               4'h5:    ik1_d  = 1'b0;
               default: ;
            endcase
         end

         it_d   = it_d | ev_clk;
         isw_d  = isw_d | ev_sw;
         ipt_d  = ipt_d | ev_pt;
         isio_d = isio_d | ev_sio;
         ik0_d  = ik0_d | (|k0Edge);
         ik1_d  = ik1_d | k1Edge;

         if (wrEn) begin
            case (bus.reg_addr)
               4'h8:    eit_d   = bus.bus_wdata;
               4'h9:    eisw_d  = bus.bus_wdata[1:0];
               4'hA:    eipt_d  = bus.bus_wdata[0];
               4'hB:    eisio_d = bus.bus_wdata[0];
               4'hC:    eik0_d  = bus.bus_wdata[K0_WIDTH-1:0];
               4'hD:    eik1_d  = bus.bus_wdata[0];
               4'hE:    kcp0_d  = bus.bus_wdata[K0_WIDTH-1:0];
               4'hF:    kcp1_d  = bus.bus_wdata[0];
               default: ;
            endcase
         end
      end
   end

   // State register; reset wins over any concurrent bus access and parks the
   // K-port history high to match the idle pull-ups.
   always_ff @(posedge clk) begin
      if (reset) begin
         it_q      <= '0;
         isw_q     <= '0;
         ipt_q     <= 1'b0;
         isio_q    <= 1'b0;
         ik0_q     <= 1'b0;
         ik1_q     <= 1'b0;
         eit_q     <= '0;
         eisw_q    <= '0;
         eipt_q    <= 1'b0;
         eisio_q   <= 1'b0;
         eik0_q    <= '0;
         eik1_q    <= 1'b0;
         kcp0_q    <= '0;
         kcp1_q    <= 1'b0;
         k0Sync1_q <= '1;
         k0Sync2_q <= '1;
         k0Prev_q  <= '1;
         k1Sync1_q <= 1'b1;
         k1Sync2_q <= 1'b1;
         k1Prev_q  <= 1'b1;
         req_q     <= '0;
      end else begin
         it_q      <= it_d;
         isw_q     <= isw_d;
         ipt_q     <= ipt_d;
         isio_q    <= isio_d;
         ik0_q     <= ik0_d;
         ik1_q     <= ik1_d;
         eit_q     <= eit_d;
         eisw_q    <= eisw_d;
         eipt_q    <= eipt_d;
         eisio_q   <= eisio_d;
         eik0_q    <= eik0_d;
         eik1_q    <= eik1_d;
         kcp0_q    <= kcp0_d;
         kcp1_q    <= kcp1_d;
         k0Sync1_q <= k0Sync1_d;
         k0Sync2_q <= k0Sync2_d;
         k0Prev_q  <= k0Prev_d;
         k1Sync1_q <= k1Sync1_d;
         k1Sync2_q <= k1Sync2_d;
         k1Prev_q  <= k1Prev_d;
         req_q     <= req_d;
      end
   end

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: a register-file model indexed by bus address
// tracks factors and masks; K pins are modelled as "the core sees the pin
// level from two ticks ago". Directed scenarios pin the model to hand-computed
// values, then randomized traffic is compared every cycle.
module tb_interrupt_controller;
   localparam int KW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          clk_en;
   logic [3:0]    ev_clk;
   logic [1:0]    ev_sw;
   logic          ev_pt;
   logic          ev_sio;
   logic [KW-1:0] k0_in;
   logic          k1_in;
   logic [14:0]   interrupt_req;

   interrupt_controller_if busIf ();

   interrupt_controller #(.K0_WIDTH(KW)) dut (
      .clk           (clk),
      .reset         (reset),
      .clk_en        (clk_en),
      .bus           (busIf.slave),
      .ev_clk        (ev_clk),
      .ev_sw         (ev_sw),
      .ev_pt         (ev_pt),
      .ev_sio        (ev_sio),
      .k0_in         (k0_in),
      .k1_in         (k1_in),
      .interrupt_req (interrupt_req)
   );

   // Free-running clock
   always #5 clk = ~clk;

   int            tests = 0;
   int            fails = 0;
   logic [3:0]    regs [0:15];
   logic [KW-1:0] k0Seen [0:2];
   logic          k1Seen [0:2];
   logic [14:0]   reqExp;
   logic [3:0]    lastRdata;

   function automatic logic [3:0] widthMask(input logic [3:0] a);
      case (a)
         4'h8, 4'hC, 4'hE: return 4'hF >> (4 - KW);
         4'h9:             return 4'h3;
         4'hA, 4'hB, 4'hD, 4'hF: return 4'h1;
         default:          return 4'h0;
      endcase
   endfunction

   function automatic logic [14:0] computeReq();
      logic [14:0] r;
      r    = '0;
      r[6] = regs[2][0] & regs[10][0];
      r[5] = regs[3][0] & regs[11][0];
      r[4] = regs[4][0];
      r[3] = regs[5][0];
      r[2] = |(regs[1] & regs[9]);
      r[1] = |(regs[0] & regs[8]);
      return r;
   endfunction

   function automatic logic [3:0] expRdata();
      if (busIf.cs && busIf.bus_rd) return regs[busIf.reg_addr];
      return 4'h0;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advances the model by one clock edge using the inputs the DUT sampled.
   task automatic modelTick();
      logic [14:0]   reqNew;
      logic [KW-1:0] k0Edge;
      logic          k1Edge;
      if (reset) begin
         for (int i = 0; i < 16; i++) regs[i] = 4'h0;
         for (int i = 0; i < 3; i++) begin
            k0Seen[i] = '1;
            k1Seen[i] = 1'b1;
         end
         reqExp = '0;
      end else if (clk_en) begin
         reqNew = computeReq();
         k0Edge = (k0Seen[1] ^ k0Seen[2]) & ~(k0Seen[1] ^ regs[14][KW-1:0]) & regs[12][KW-1:0];
         k1Edge = (k1Seen[1] ^ k1Seen[2]) & ~(k1Seen[1] ^ regs[15][0]) & regs[13][0];
         if (busIf.cs && busIf.bus_rd && busIf.reg_addr <= 4'h5) regs[busIf.reg_addr] = 4'h0;
         regs[0] = regs[0] | ev_clk;
         regs[1] = regs[1] | {2'b00, ev_sw};
         regs[2] = regs[2] | {3'b000, ev_pt};
         regs[3] = regs[3] | {3'b000, ev_sio};
         if (|k0Edge) regs[4] = 4'h1;
         if (k1Edge)  regs[5] = 4'h1;
         if (busIf.cs && busIf.bus_wr && busIf.reg_addr >= 4'h8)
            regs[busIf.reg_addr] = busIf.bus_wdata & widthMask(busIf.reg_addr);
         k0Seen[2] = k0Seen[1];
         k0Seen[1] = k0Seen[0];
         k0Seen[0] = k0_in;
         k1Seen[2] = k1Seen[1];
         k1Seen[1] = k1Seen[0];
         k1Seen[0] = k1_in;
         reqExp = reqNew;
      end
   endtask

   // Called just after a falling edge with inputs already set: compare, then
   // run one rising edge through the model, then return after the next fall.
   task automatic step();
      #1;
      lastRdata = busIf.bus_rdata;
      checkOutput("bus_rdata", busIf.bus_rdata, expRdata());
      checkOutput("interrupt_req", interrupt_req, reqExp);
      @(posedge clk);
      modelTick();
      @(negedge clk);
   endtask

   task automatic idle();
      reset           = 1'b0;
      clk_en          = 1'b1;
      busIf.cs        = 1'b0;
      busIf.reg_addr  = 4'h0;
      busIf.bus_wr    = 1'b0;
      busIf.bus_rd    = 1'b0;
      busIf.bus_wdata = 4'h0;
      ev_clk          = 4'h0;
      ev_sw           = 2'b00;
      ev_pt           = 1'b0;
      ev_sio          = 1'b0;
   endtask

   task automatic busWrite(input logic [3:0] a, input logic [3:0] d);
      idle();
      busIf.cs        = 1'b1;
      busIf.bus_wr    = 1'b1;
      busIf.reg_addr  = a;
      busIf.bus_wdata = d;
      step();
      idle();
   endtask

   task automatic busRead(input logic [3:0] a);
      idle();
      busIf.cs       = 1'b1;
      busIf.bus_rd   = 1'b1;
      busIf.reg_addr = a;
      step();
      idle();
   endtask

   task automatic applyStimulus();
      reset           = ($urandom_range(0, 199) == 0);
      clk_en          = ($urandom_range(0, 99) < 80);
      busIf.cs        = $urandom_range(0, 1) == 1;
      busIf.reg_addr  = 4'($urandom_range(0, 15));
      busIf.bus_rd    = ($urandom_range(0, 9) < 4);
      busIf.bus_wr    = ($urandom_range(0, 9) < 3);
      busIf.bus_wdata = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) ev_clk[i] = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < 2; i++) ev_sw[i] = ($urandom_range(0, 7) == 0);
      ev_pt  = ($urandom_range(0, 7) == 0);
      ev_sio = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) k0_in = k0_in ^ KW'($urandom_range(1, (1 << KW) - 1));
      if ($urandom_range(0, 11) == 0) k1_in = ~k1_in;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      k0_in = '1;
      k1_in = 1'b1;
      repeat (2) begin
         @(posedge clk);
         modelTick();
      end
      @(negedge clk);
      step();
      idle();

      // Reset state
      checkOutput("reset_req", interrupt_req, 15'h0000);
      busRead(4'h8);
      checkOutput("reset_eit", lastRdata, 4'h0);

      // PT factor latches regardless of mask; enabling mask raises bit 6
      ev_pt = 1'b1;
      step();
      busWrite(4'hA, 4'h1);
      checkOutput("pt_masked_req", interrupt_req, 15'h0000);
      step();
      checkOutput("pt_req", interrupt_req, 15'h0040);
      busRead(4'h2);
      checkOutput("ipt_read", lastRdata, 4'h1);
      step();
      checkOutput("pt_cleared_req", interrupt_req, 15'h0000);

      // Clock-timer factors with a partial mask, then read-clear
      busWrite(4'h8, 4'b0100);
      ev_clk = 4'b0101;
      step();
      idle();
      step();
      checkOutput("clk_req", interrupt_req, 15'h0002);
      busRead(4'h0);
      checkOutput("it_read", lastRdata, 4'h5);
      step();
      checkOutput("clk_cleared_req", interrupt_req, 15'h0000);
      busRead(4'h0);
      checkOutput("it_reread", lastRdata, 4'h0);

      // Read-clear racing a new stopwatch event: the set wins
      ev_sw = 2'b10;
      step();
      idle();
      busIf.cs       = 1'b1;
      busIf.bus_rd   = 1'b1;
      busIf.reg_addr = 4'h1;
      ev_sw          = 2'b01;
      step();
      checkOutput("isw_race_read", lastRdata, 4'h2);
      busRead(4'h1);
      checkOutput("isw_after_race", lastRdata, 4'h1);

      // K0 falling edge on enabled pin 0 reaches the request 4 ticks later
      busWrite(4'hC, 4'h1);
      busWrite(4'hE, 4'h0);
      k0_in[0] = 1'b0;
      repeat (3) step();
      checkOutput("k0_req_t3", interrupt_req[4], 1'b0);
      step();
      checkOutput("k0_req_t4", interrupt_req[4], 1'b1);
      busRead(4'h4);
      checkOutput("ik0_read", lastRdata, 4'h1);
      k0_in[1] = 1'b0;
      repeat (5) step();
      checkOutput("k0_disabled_req", interrupt_req[4], 1'b0);
      busRead(4'h4);
      checkOutput("ik0_disabled", lastRdata, 4'h0);

      // Simultaneous PT, SIO and CLK requests, then clear PT
      busWrite(4'hB, 4'h1);
      busWrite(4'h8, 4'hF);
      ev_pt  = 1'b1;
      ev_sio = 1'b1;
      ev_clk = 4'b0001;
      step();
      idle();
      step();
      checkOutput("multi_req", interrupt_req, 15'h0062);
      busRead(4'h2);
      step();
      checkOutput("multi_pt_cleared", interrupt_req, 15'h0022);

      // Reset during an active write discards the write
      reset           = 1'b1;
      busIf.cs        = 1'b1;
      busIf.bus_wr    = 1'b1;
      busIf.reg_addr  = 4'h8;
      busIf.bus_wdata = 4'hF;
      step();
      checkOutput("reset_mid_req", interrupt_req, 15'h0000);
      idle();
      busRead(4'h8);
      checkOutput("reset_mid_eit", lastRdata, 4'h0);
      busRead(4'h0);
      checkOutput("reset_mid_it", lastRdata, 4'h0);
      busRead(4'hA);
      checkOutput("reset_mid_eipt", lastRdata, 4'h0);

      // Randomized traffic against the model
      k0_in = '1;
      k1_in = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         applyStimulus();
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
